spi_slave_rx: RTL and testbench

SPI slave front end that oversamples the raw SPI pins on the system clock, recovers the serial MOSI stream, and presents it to the downstream state machine as one registered bit plus a one-cycle valid strobe per SPI sample edge. It also assembles MSB-first words for other consumers, flags truncated frames, and shifts a parallel reply word out on MISO. It is the stage directly upstream of the SPI-driven FSM; `o_Bit`/`o_Bit_DV` feed that FSM's data input and clock enable.

---
 rtl/spi_slave_rx.sv | 127 ++++++++++++
 tb/tb_spi_slave_rx.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: oversampled SPI slave that strobes out each MOSI bit, assembles words and replies on MISO
module spi_slave_rx #(
  parameter int WIDTH    = 8,
  parameter int SPI_MODE = 0
) (
  input  logic             i_Clk,
  input  logic             RESET_N,
  input  logic             i_SPI_Clk,
  input  logic             i_SPI_MOSI,
  input  logic             i_SPI_CS_n,
  output logic             o_SPI_MISO,
  input  logic [WIDTH-1:0] i_TX_Byte,
  output logic             o_Bit,
  output logic             o_Bit_DV,
  output logic [WIDTH-1:0] o_RX_Byte,
  output logic             o_RX_DV,
  output logic             o_Busy,
  output logic             o_Frame_Err
);
  localparam logic CPOL = ((SPI_MODE >> 1) & 1) != 0;
  localparam logic CPHA = (SPI_MODE & 1) != 0;
  localparam int   CW   = $clog2(WIDTH);
  typedef enum logic [1:0] {WAIT_HIGH, IDLE, ACTIVE} state_t;
  state_t state_q, state_d;
  logic [2:0] sck_q, mosi_q, cs_q;
  logic [1:0] flush_q, flush_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rx_q, rx_d, tx_q, tx_d, rx_byte_q, rx_byte_d;
  logic miso_q, miso_d, bit_q, bit_d, bit_dv_q, bit_dv_d, rx_dv_q, rx_dv_d, ferr_q, ferr_d;
  logic sck_rise, sck_fall, sample_edge, shift_edge, cs_fall, cs_rise, last;
  assign sck_rise    = sck_q[1] & ~sck_q[2];
  assign sck_fall    = ~sck_q[1] & sck_q[2];
  assign sample_edge = (CPOL == CPHA) ? sck_rise : sck_fall;
  assign shift_edge  = (CPOL == CPHA) ? sck_fall : sck_rise;
  assign cs_fall     = cs_q[2] & ~cs_q[1];
  assign cs_rise     = ~cs_q[2] & cs_q[1];
  assign last        = cnt_q == CW'(WIDTH - 1);
  // The sync chain resets to "CS high", so WAIT_HIGH first flushes it to see the real pin level.
  always_comb begin
    state_d   = state_q;
    flush_d   = flush_q;
    cnt_d     = cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    miso_d    = miso_q;
    bit_d     = bit_q;
    bit_dv_d  = 1'b0;
    rx_byte_d = rx_byte_q;
    rx_dv_d   = 1'b0;
    ferr_d    = 1'b0;
    unique case (state_q)
      WAIT_HIGH: begin
        flush_d = (flush_q == 2'd2) ? flush_q : flush_q + 2'd1;
        state_d = (flush_q == 2'd2 && cs_q[1]) ? IDLE : WAIT_HIGH;
      end
      IDLE: begin
        if (cs_fall) begin
          state_d = ACTIVE;
          cnt_d   = '0;
          tx_d    = i_TX_Byte;
          miso_d  = 1'b0;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d = IDLE;
          ferr_d  = cnt_q != '0;
        end else if (sample_edge) begin
          bit_d    = mosi_q[1];
          bit_dv_d = 1'b1;
          rx_d     = {rx_q[WIDTH-2:0], mosi_q[1]};
          cnt_d    = last ? '0 : cnt_q + CW'(1);
          if (last) begin
            rx_byte_d = rx_d;
            rx_dv_d   = 1'b1;
            tx_d      = i_TX_Byte;
          end
        end else if (shift_edge && (CPHA || cnt_q != '0)) begin
          // With CPHA=0 the idle-going edge right after a word boundary must keep the fresh MSB.
          miso_d = tx_q[WIDTH-1];
          tx_d   = {tx_q[WIDTH-2:0], 1'b0};
        end
      end
      default: state_d = WAIT_HIGH;
    endcase
  end
  always_ff @(posedge i_Clk) begin
    if (!RESET_N) begin
      sck_q     <= {3{CPOL}};
      mosi_q    <= '0;
      cs_q      <= '1;
      state_q   <= WAIT_HIGH;
      flush_q   <= '0;
      cnt_q     <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      miso_q    <= 1'b0;
      bit_q     <= 1'b0;
      bit_dv_q  <= 1'b0;
      rx_byte_q <= '0;
      rx_dv_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      sck_q     <= {sck_q[1:0], i_SPI_Clk};
      mosi_q    <= {mosi_q[1:0], i_SPI_MOSI};
      cs_q      <= {cs_q[1:0], i_SPI_CS_n};
      state_q   <= state_d;
      flush_q   <= flush_d;
      cnt_q     <= cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      miso_q    <= miso_d;
      bit_q     <= bit_d;
      bit_dv_q  <= bit_dv_d;
      rx_byte_q <= rx_byte_d;
      rx_dv_q   <= rx_dv_d;
      ferr_q    <= ferr_d;
    end
  end
  assign o_SPI_MISO  = (state_q == ACTIVE) && (CPHA ? miso_q : tx_q[WIDTH-1]);
  assign o_Busy      = state_q == ACTIVE;
  assign o_Bit       = bit_q;
  assign o_Bit_DV    = bit_dv_q;
  assign o_RX_Byte   = rx_byte_q;
  assign o_RX_DV     = rx_dv_q;
  assign o_Frame_Err = ferr_q;
endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: drives a mode-0 and a mode-3 slave as an SPI master and checks against a word-level model
module tb_spi_slave_rx;
  localparam int HP = 6;
  logic clk = 1'b0, rst_n = 1'b0;
  logic sck0 = 1'b0, sck3 = 1'b1, cs0 = 1'b1, cs3 = 1'b1, mosi = 1'b0;
  logic [7:0] tx = 8'h00;
  logic miso0, bit0, dv0, rxdv0, busy0, fe0_o;
  logic miso3, bit3, dv3, rxdv3, busy3, fe3_o;
  logic [7:0] rxb0, rxb3;
  int errors = 0, checks = 0;
  logic bq0[$], bq3[$];
  logic [7:0] wq0[$], wq3[$];
  int fe0 = 0, fe3 = 0;
  logic busy_ok;
  always #5 clk = ~clk;
  spi_slave_rx #(.WIDTH(8), .SPI_MODE(0)) u0 (
    .i_Clk(clk), .RESET_N(rst_n), .i_SPI_Clk(sck0), .i_SPI_MOSI(mosi), .i_SPI_CS_n(cs0),
    .o_SPI_MISO(miso0), .i_TX_Byte(tx), .o_Bit(bit0), .o_Bit_DV(dv0), .o_RX_Byte(rxb0),
    .o_RX_DV(rxdv0), .o_Busy(busy0), .o_Frame_Err(fe0_o));
  spi_slave_rx #(.WIDTH(8), .SPI_MODE(3)) u3 (
    .i_Clk(clk), .RESET_N(rst_n), .i_SPI_Clk(sck3), .i_SPI_MOSI(mosi), .i_SPI_CS_n(cs3),
    .o_SPI_MISO(miso3), .i_TX_Byte(tx), .o_Bit(bit3), .o_Bit_DV(dv3), .o_RX_Byte(rxb3),
    .o_RX_DV(rxdv3), .o_Busy(busy3), .o_Frame_Err(fe3_o));
  always @(negedge clk) begin
    if (dv0) bq0.push_back(bit0);
    if (rxdv0) wq0.push_back(rxb0);
    if (fe0_o) fe0++;
    if (dv3) bq3.push_back(bit3);
    if (rxdv3) wq3.push_back(rxb3);
    if (fe3_o) fe3++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic mark(input bit m3, output int bb, output int wb, output int fb);
    bb = m3 ? bq3.size() : bq0.size();
    wb = m3 ? wq3.size() : wq0.size();
    fb = m3 ? fe3 : fe0;
  endtask
  task automatic send_bit(input bit m3, input logic b, input bit cs_up, output logic mi);
    if (m3) sck3 = 1'b0;
    mosi = b;
    wait_clk(HP);
    mi = m3 ? miso3 : miso0;
    busy_ok &= m3 ? busy3 : busy0;
    if (m3) sck3 = 1'b1; else sck0 = 1'b1;
    if (cs_up) cs0 = 1'b1;
    wait_clk(HP);
    if (!m3) sck0 = 1'b0;
  endtask
  task automatic frame(input bit m3, input logic [15:0] d, input int n, input bit coinc, output logic [15:0] got);
    logic mi;
    got = '0;
    busy_ok = 1'b1;
    if (m3) cs3 = 1'b0; else cs0 = 1'b0;
    wait_clk(HP);
    for (int i = 0; i < n; i++) begin
      send_bit(m3, d[15-i], coinc && i == n - 1, mi);
      got[15-i] = mi;
    end
    wait_clk(HP);
    if (m3) cs3 = 1'b1; else cs0 = 1'b1;
    wait_clk(2 * HP);
  endtask
  // nb = bits the slave should accept; ns = bits the master clocked (reply compared over those)
  task automatic check_rx(input string tag, input bit m3, input logic [15:0] d, input int nb,
                          input int bb, input int wb, input int fb, input logic [15:0] mrx, input int ns);
    logic [15:0] gb, gw;
    int nbits, nw, nf;
    gb = '0;
    gw = '0;
    nbits = (m3 ? bq3.size() : bq0.size()) - bb;
    nw = (m3 ? wq3.size() : wq0.size()) - wb;
    nf = (m3 ? fe3 : fe0) - fb;
    for (int i = bb; i < bb + nbits; i++) gb = {gb[14:0], m3 ? bq3[i] : bq0[i]};
    for (int i = wb; i < wb + nw; i++) gw = {gw[7:0], m3 ? wq3[i] : wq0[i]};
    chk({tag, ".nbits"}, nbits, nb);
    chk({tag, ".bits"}, gb, d >> (16 - nb));
    chk({tag, ".nwords"}, nw, nb / 8);
    chk({tag, ".words"}, gw, d >> (16 - 8 * (nb / 8)));
    chk({tag, ".frame_err"}, nf, (nb % 8 != 0) ? 1 : 0);
    chk({tag, ".miso"}, mrx >> (16 - ns), {tx, tx} >> (16 - ns));
    chk({tag, ".busy"}, busy_ok, 1);
  endtask
  initial begin
    logic [15:0] m, d;
    logic mi, acc;
    int bb, wb, fb, n;
    bit m3;
    wait_clk(4);
    chk("reset.u0", {bit0, dv0, rxb0, rxdv0, busy0, fe0_o, miso0}, 0);
    chk("reset.u3", {bit3, dv3, rxb3, rxdv3, busy3, fe3_o, miso3}, 0);
    rst_n = 1'b1;
    wait_clk(10);
    tx = 8'h3C;
    mark(0, bb, wb, fb);
    frame(0, 16'hA500, 8, 0, m);
    check_rx("m0_a5", 0, 16'hA500, 8, bb, wb, fb, m, 8);
    tx = 8'h96;
    mark(1, bb, wb, fb);
    frame(1, 16'h0FF0, 16, 0, m);
    check_rx("m3_two", 1, 16'h0FF0, 16, bb, wb, fb, m, 16);
    tx = 8'hC3;
    mark(0, bb, wb, fb);
    frame(0, 16'hFF00, 5, 0, m);
    check_rx("trunc", 0, 16'hFF00, 5, bb, wb, fb, m, 5);
    mark(0, bb, wb, fb);
    frame(0, 16'h8100, 8, 0, m);
    check_rx("after_trunc", 0, 16'h8100, 8, bb, wb, fb, m, 8);
    mark(0, bb, wb, fb);
    acc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sck0 = ~sck0;
      wait_clk(3);
      acc |= busy0 | miso0;
      wait_clk(3);
    end
    chk("cs_idle.nbits", bq0.size() - bb, 0);
    chk("cs_idle.busy_miso", acc, 0);
    tx = 8'h77;
    busy_ok = 1'b1;
    cs0 = 1'b0;
    wait_clk(HP);
    for (int i = 0; i < 4; i++) send_bit(0, i[0], 0, mi);
    rst_n = 1'b0;
    wait_clk(1);
    chk("mid_reset.outs", {bit0, dv0, rxb0, rxdv0, busy0, fe0_o, miso0}, 0);
    wait_clk(2);
    rst_n = 1'b1;
    mark(0, bb, wb, fb);
    acc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_bit(0, 1'b1, 0, mi);
      acc |= busy0 | mi;
    end
    wait_clk(HP);
    chk("mid_reset.nbits", bq0.size() - bb, 0);
    chk("mid_reset.nwords", wq0.size() - wb, 0);
    chk("mid_reset.ferr", fe0 - fb, 0);
    chk("mid_reset.busy_miso", acc, 0);
    cs0 = 1'b1;
    wait_clk(2 * HP);
    tx = 8'h2D;
    mark(0, bb, wb, fb);
    frame(0, 16'h5A00, 8, 0, m);
    check_rx("after_reset", 0, 16'h5A00, 8, bb, wb, fb, m, 8);
    tx = 8'hE1;
    mark(0, bb, wb, fb);
    frame(0, 16'hB300, 4, 1, m);
    check_rx("coinc", 0, 16'hB300, 3, bb, wb, fb, m, 4);
    for (int r = 0; r < 8; r++) begin
      m3 = 1'($urandom_range(0, 1));
      n = ($urandom_range(0, 1) != 0) ? 16 : 8;
      d = 16'($urandom);
      tx = 8'($urandom);
      mark(m3, bb, wb, fb);
      frame(m3, d, n, 0, m);
      check_rx($sformatf("rand%0d", r), m3, d, n, bb, wb, fb, m, n);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
